stage_audio_output: RTL and testbench

//   Final pipeline stage after stage_sample_generator. Buffers each 16-bit mixed sample in a small FIFO.

---
 rtl/stage_audio_output.sv | 210 +++++++++++++++++++++
 tb/tb_stage_audio_output.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_audio_output.sv
`default_nettype none
// ============================================================================
// Module      : stage_audio_output
// Description : Last stage of the audio pipeline. Mixed 16-bit samples are
//               queued in a small FIFO. Each sample is sent to an external DAC
//               as a Philips I2S frame. The mono sample is repeated on the
//               left and right channels. Overflow and underflow are reported
//               as sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_audio_output #(
    parameter int FIFO_DEPTH  = 4,
    parameter int START_LEVEL = 2,
    parameter int BCLK_DIV    = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_Enable,
    input  logic                          i_SampleReady,
    input  logic [15:0]                   i_Sample,
    output logic                          o_I2S_BCLK,
    output logic                          o_I2S_LRCLK,
    output logic                          o_I2S_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
    output logic                          o_Overflow,
    output logic                          o_Underflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_DW-1:0] c_DIV_TC = c_DW'(BCLK_DIV - 1);
    localparam logic [c_AW:0]   c_DEPTH  = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_START  = (c_AW+1)'(START_LEVEL);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Sample FIFO
    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_level;
    logic               r_overflow;
    logic               r_underflow;

    // Serialiser
    logic [c_DW-1:0]    r_div;
    logic               r_bclk;
    logic               r_lrclk;
    logic [4:0]         r_slot;
    logic [15:0]        r_shift;
    logic [15:0]        r_hold;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_stop;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [15:0]        w_pop_data;
    logic               w_tc;
    logic               w_bclk_fall;
    logic               w_frame_wrap;
    logic [4:0]         w_slot_next;

    assign w_full       = (r_level == c_DEPTH);
    assign w_empty      = (r_level == '0);
    // A pop from an empty FIFO supplies silence.
    assign w_pop_data   = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    // When full, a write is still accepted if the same cycle frees a slot.
    assign w_wr_en      = i_SampleReady && (!w_full || w_pop);
    assign w_rd_en      = w_pop && !w_empty;

    assign w_tc         = (r_div == c_DIV_TC);
    assign w_bclk_fall  = (r_state == S_RUN) && w_tc && r_bclk;
    assign w_slot_next  = r_slot + 5'd1;
    assign w_frame_wrap = w_bclk_fall && (r_slot == 5'd31);

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, FIFO pop request and stop request
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Enable && (r_level >= c_START)) begin
                    w_state_next = S_RUN;
                    w_pop        = 1'b1;
                end
            end
            S_RUN: begin
                if (w_frame_wrap) begin
                    if (!i_Enable) begin
                        w_state_next = S_IDLE;
                        w_stop       = 1'b1;
                    end else begin
                        w_pop        = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FIFO storage. Data needs no reset because the level gates every read.
    always_ff @(posedge i_Clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_Sample;
        end
    end

    // FIFO pointers, level and sticky status flags
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (i_SampleReady && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // I2S bit-clock divider, slot counter and data/word-select shifter
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_slot  <= '0;
            r_shift <= '0;
            r_hold  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_pop) begin
                r_div   <= '0;
                r_bclk  <= 1'b0;
                r_lrclk <= 1'b0;
                r_slot  <= '0;
                r_shift <= w_pop_data;
                r_hold  <= w_pop_data;
            end
        end else begin
            r_div <= w_tc ? '0 : r_div + 1'b1;
            if (w_tc) begin
                r_bclk <= ~r_bclk;
            end
            // Data and word select change only on BCLK falling edges.
            if (w_bclk_fall) begin
                r_slot  <= w_slot_next;
                r_lrclk <= (w_slot_next >= 5'd15) && (w_slot_next <= 5'd30);
                if (w_stop) begin
                    r_div   <= '0;
                    r_bclk  <= 1'b0;
                    r_lrclk <= 1'b0;
                    r_slot  <= '0;
                    r_shift <= '0;
                end else if (w_pop) begin
                    r_shift <= w_pop_data;
                    r_hold  <= w_pop_data;
                end else if (w_slot_next == 5'd16) begin
                    r_shift <= r_hold;
                end else begin
                    r_shift <= {r_shift[14:0], 1'b0};
                end
            end
        end
    end

    assign o_I2S_BCLK  = r_bclk;
    assign o_I2S_LRCLK = r_lrclk;
    assign o_I2S_DATA  = r_shift[15];
    assign o_FifoLevel = r_level;
    assign o_Overflow  = r_overflow;
    assign o_Underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_stage_audio_output.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_audio_output
// Description : Self-checking bench for stage_audio_output. A monitor decodes
//               the I2S stream into left/right words, and a scoreboard queue
//               holds the expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_audio_output;

    localparam int BCLK_DIV = 4;

    logic        i_Clock       = 1'b0;
    logic        i_Reset_n     = 1'b0;
    logic        i_Enable      = 1'b0;
    logic        i_SampleReady = 1'b0;
    logic [15:0] i_Sample      = 16'h0000;
    logic        o_I2S_BCLK;
    logic        o_I2S_LRCLK;
    logic        o_I2S_DATA;
    logic [2:0]  o_FifoLevel;
    logic        o_Overflow;
    logic        o_Underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected words, plus the decoded words from the monitor
    logic [15:0] exp_q [$];
    logic [15:0] obs_l [$];
    logic [15:0] obs_r [$];
    logic        obs_ok [$];

    stage_audio_output #(
        .FIFO_DEPTH  (4),
        .START_LEVEL (2),
        .BCLK_DIV    (BCLK_DIV)
    ) dut (
        .i_Clock       (i_Clock),
        .i_Reset_n     (i_Reset_n),
        .i_Enable      (i_Enable),
        .i_SampleReady (i_SampleReady),
        .i_Sample      (i_Sample),
        .o_I2S_BCLK    (o_I2S_BCLK),
        .o_I2S_LRCLK   (o_I2S_LRCLK),
        .o_I2S_DATA    (o_I2S_DATA),
        .o_FifoLevel   (o_FifoLevel),
        .o_Overflow    (o_Overflow),
        .o_Underflow   (o_Underflow)
    );

    always #5 i_Clock = ~i_Clock;

    // I2S receiver. It samples on BCLK rising edges and restarts its slot
    // count after a long BCLK-low gap, which marks a fresh start from idle.
    int          m_slot = 0;
    int          m_idle = 1000;
    logic        m_prev = 1'b0;
    logic        m_bad  = 1'b0;
    logic [15:0] m_sh   = 16'h0000;
    logic [15:0] m_left = 16'h0000;

    always @(negedge i_Clock) begin
        if (!i_Reset_n) begin
            m_idle = 1000;
            m_prev = 1'b0;
        end else begin
            if (o_I2S_BCLK && !m_prev) begin
                if (m_idle > 2 * BCLK_DIV) begin
                    m_slot = 0;
                    m_bad  = 1'b0;
                end
                m_sh = {m_sh[14:0], o_I2S_DATA};
                if (o_I2S_LRCLK !== ((m_slot >= 15) && (m_slot <= 30))) begin
                    m_bad = 1'b1;
                end
                if (m_slot == 15) begin
                    m_left = m_sh;
                end
                if (m_slot == 31) begin
                    obs_l.push_back(m_left);
                    obs_r.push_back(m_sh);
                    obs_ok.push_back(!m_bad);
                    m_bad = 1'b0;
                end
                m_slot = (m_slot + 1) % 32;
                m_idle = 0;
            end else begin
                m_idle = m_idle + 1;
            end
            m_prev = o_I2S_BCLK;
        end
    end

    // Pops one decoded frame and the matching expectation as {lr_ok, R, L}
    task automatic pop_pair(output logic [32:0] got, output logic [32:0] want);
        logic        ok;
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] e;
        ok  = obs_ok.pop_front();
        r   = obs_r.pop_front();
        l   = obs_l.pop_front();
        got = {ok, r, l};
        if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            want = {1'b1, e, e};
        end else begin
            want = 'x;
        end
    endtask

    task automatic test_reset();
        i_Reset_n     = 1'b0;
        i_Enable      = 1'b0;
        i_SampleReady = 1'b0;
        repeat (3) @(negedge i_Clock);
        n_checks++;
        if ({o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held: outputs %b required 0", {o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel});
        end
        i_Reset_n = 1'b1;
        repeat (2) @(negedge i_Clock);
        n_checks++;
        if ({o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: outputs %b required 0", {o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel});
        end
    endtask

    task automatic test_basic();
        int          n;
        int          b1;
        int          b2;
        int          l1;
        int          l2;
        logic        pb;
        logic        pl;
        logic [32:0] got;
        logic [32:0] want;
        i_Enable      = 1'b1;
        i_SampleReady = 1'b1;
        i_Sample      = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        @(negedge i_Clock);
        i_Sample = 16'h0001;
        exp_q.push_back(16'h0001);
        n_checks++;
        if (o_FifoLevel !== 3'd1 || o_I2S_BCLK !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first_write: level=%0d bclk=%b required level=1 bclk=0", o_FifoLevel, o_I2S_BCLK);
        end
        @(negedge i_Clock);
        i_SampleReady = 1'b0;
        n_checks++;
        if (o_FifoLevel !== 3'd2 || o_I2S_DATA !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_second_write: level=%0d data=%b required level=2 data=0", o_FifoLevel, o_I2S_DATA);
        end
        @(negedge i_Clock);
        n_checks++;
        if ({o_FifoLevel, o_I2S_DATA, o_I2S_BCLK, o_I2S_LRCLK} !== {3'd1, 3'b100}) begin
            n_fail++;
            $display("FAIL basic_run_entry: level=%0d data=%b bclk=%b lrclk=%b required 1 1 0 0", o_FifoLevel, o_I2S_DATA, o_I2S_BCLK, o_I2S_LRCLK);
        end
        i_SampleReady = 1'b1;
        i_Sample      = 16'h8000;
        exp_q.push_back(16'h8000);
        @(negedge i_Clock);
        i_SampleReady = 1'b0;
        n  = 1;
        b1 = -1;
        b2 = -1;
        l1 = -1;
        l2 = -1;
        pb = 1'b0;
        pl = 1'b0;
        while (n <= 380) begin
            if (o_I2S_BCLK && !pb) begin
                if (b1 < 0) b1 = n;
                else if (b2 < 0) b2 = n;
            end
            if (o_I2S_LRCLK && !pl) begin
                if (l1 < 0) l1 = n;
                else if (l2 < 0) l2 = n;
            end
            pb = o_I2S_BCLK;
            pl = o_I2S_LRCLK;
            if (n < 380) @(negedge i_Clock);
            n++;
        end
        n_checks++;
        if (b1 != 4) begin
            n_fail++;
            $display("FAIL basic_first_bclk_rise: clock %0d required 4", b1);
        end
        n_checks++;
        if (b2 - b1 != 2 * BCLK_DIV) begin
            n_fail++;
            $display("FAIL basic_bclk_period: %0d clocks required %0d", b2 - b1, 2 * BCLK_DIV);
        end
        n_checks++;
        if (l1 != 15 * 2 * BCLK_DIV) begin
            n_fail++;
            $display("FAIL basic_lrclk_rise: clock %0d required %0d", l1, 15 * 2 * BCLK_DIV);
        end
        n_checks++;
        if (l2 - l1 != 64 * BCLK_DIV) begin
            n_fail++;
            $display("FAIL basic_frame_period: %0d clocks required %0d", l2 - l1, 64 * BCLK_DIV);
        end
        n_checks++;
        if (obs_l.size() == 0) begin
            n_fail++;
            $display("FAIL basic_frame_seen: 0 frames decoded, required at least 1");
        end
        while (obs_l.size() != 0) begin
            pop_pair(got, want);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL basic_word: got {lr_ok,R,L}=%h required %h", got, want);
            end
        end
    endtask

    task automatic test_steady();
        logic [15:0] s;
        logic [32:0] got;
        logic [32:0] want;
        for (int k = 0; k < 100; k++) begin
            s             = {k[7:0] ^ 8'h5A, 8'(k * 37)};
            i_SampleReady = 1'b1;
            i_Sample      = s;
            exp_q.push_back(s);
            for (int c = 0; c < 256; c++) begin
                @(negedge i_Clock);
                i_SampleReady = 1'b0;
                n_checks++;
                if (o_FifoLevel !== 3'd1 && o_FifoLevel !== 3'd2) begin
                    n_fail++;
                    $display("FAIL steady_level: frame %0d level=%0d required 1..2", k, o_FifoLevel);
                end
            end
            n_checks++;
            if (o_Overflow !== 1'b0 || o_Underflow !== 1'b0) begin
                n_fail++;
                $display("FAIL steady_flags: ovf=%b unf=%b required 0 0", o_Overflow, o_Underflow);
            end
            while (obs_l.size() != 0) begin
                pop_pair(got, want);
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL steady_word: got {lr_ok,R,L}=%h required %h", got, want);
                end
            end
        end
    endtask

    task automatic test_underflow();
        int          n;
        logic [32:0] got;
        logic [32:0] want;
        n = 0;
        while (o_Underflow !== 1'b1 && n < 1500) begin
            @(negedge i_Clock);
            n++;
        end
        n_checks++;
        if (o_Underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_flag: flag=%b after %0d clocks required 1", o_Underflow, n);
        end
        n_checks++;
        if (o_FifoLevel !== 3'd0) begin
            n_fail++;
            $display("FAIL underflow_level: level=%0d required 0", o_FifoLevel);
        end
        exp_q.push_back(16'h0000);
        // Place a strobe exactly on the next frame-start pop of an empty FIFO.
        repeat (255) @(negedge i_Clock);
        i_SampleReady = 1'b1;
        i_Sample      = 16'h1234;
        @(negedge i_Clock);
        i_SampleReady = 1'b0;
        n_checks++;
        if (o_FifoLevel !== 3'd1) begin
            n_fail++;
            $display("FAIL underflow_pop_write: level=%0d required 1", o_FifoLevel);
        end
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h1234);
        n_checks++;
        if (o_Underflow !== 1'b1 || o_Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_sticky: unf=%b ovf=%b required 1 0", o_Underflow, o_Overflow);
        end
        while (obs_l.size() != 0) begin
            pop_pair(got, want);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL underflow_word: got {lr_ok,R,L}=%h required %h", got, want);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [32:0] got;
        logic [32:0] want;
        // Continues from one clock after an empty-pop frame start.
        repeat (298) @(negedge i_Clock);
        i_Enable = 1'b0;
        repeat (213) @(negedge i_Clock);
        n_checks++;
        if (o_I2S_BCLK !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_completes_frame: bclk=%b in slot 31 required 1", o_I2S_BCLK);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge i_Clock);
            n_checks++;
            if ({o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA} !== 3'b000) begin
                n_fail++;
                $display("FAIL drop_idle_outputs: clock %0d bclk/lr/data=%b required 000", c, {o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA});
            end
        end
        n_checks++;
        if (o_FifoLevel !== 3'd0) begin
            n_fail++;
            $display("FAIL drop_level: level=%0d required 0", o_FifoLevel);
        end
        while (obs_l.size() != 0) begin
            pop_pair(got, want);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL drop_word: got {lr_ok,R,L}=%h required %h", got, want);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drop_words_missing: %0d words not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [15:0] vals [5];
        int          n;
        logic [32:0] got;
        logic [32:0] want;
        vals = '{16'h1111, 16'hF222, 16'h3333, 16'h7FFF, 16'h5555};
        for (int k = 0; k < 5; k++) begin
            i_SampleReady = 1'b1;
            i_Sample      = vals[k];
            if (k < 4) exp_q.push_back(vals[k]);
            @(negedge i_Clock);
            if (k == 3) begin
                n_checks++;
                if (o_FifoLevel !== 3'd4 || o_Overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL overflow_fill: level=%0d ovf=%b required 4 0", o_FifoLevel, o_Overflow);
                end
            end
        end
        i_SampleReady = 1'b0;
        n_checks++;
        if (o_FifoLevel !== 3'd4 || o_Overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drop: level=%0d ovf=%b required 4 1", o_FifoLevel, o_Overflow);
        end
        i_Enable = 1'b1;
        n = 0;
        while (obs_l.size() < 4 && n < 1500) begin
            @(negedge i_Clock);
            n++;
        end
        i_Enable = 1'b0;
        n_checks++;
        if (obs_l.size() < 4) begin
            n_fail++;
            $display("FAIL overflow_frames: %0d frames after %0d clocks required 4", obs_l.size(), n);
        end
        repeat (300) @(negedge i_Clock);
        n_checks++;
        if ({o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_FifoLevel} !== 6'd0) begin
            n_fail++;
            $display("FAIL overflow_idle: bclk/lr/data/level=%b required 0", {o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_FifoLevel});
        end
        while (obs_l.size() != 0) begin
            pop_pair(got, want);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL overflow_word: got {lr_ok,R,L}=%h required %h", got, want);
            end
        end
    endtask

    task automatic test_reset_midframe();
        n_checks++;
        if (o_Overflow !== 1'b1 || o_Underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_flags_before: ovf=%b unf=%b required 1 1", o_Overflow, o_Underflow);
        end
        i_Enable      = 1'b1;
        i_SampleReady = 1'b1;
        i_Sample      = 16'hAAAA;
        @(negedge i_Clock);
        i_Sample = 16'h5555;
        @(negedge i_Clock);
        i_SampleReady = 1'b0;
        repeat (80) @(negedge i_Clock);
        n_checks++;
        if (o_FifoLevel !== 3'd1) begin
            n_fail++;
            $display("FAIL midreset_running_level: level=%0d required 1", o_FifoLevel);
        end
        #3;
        i_Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel} !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_async: outputs %b required 0", {o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel});
        end
        i_Enable = 1'b0;
        @(negedge i_Clock);
        i_Reset_n = 1'b1;
        repeat (20) @(negedge i_Clock);
        n_checks++;
        if ({o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel} !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_after: outputs %b required 0", {o_I2S_BCLK, o_I2S_LRCLK, o_I2S_DATA, o_Overflow, o_Underflow, o_FifoLevel});
        end
        exp_q.delete();
        obs_l.delete();
        obs_r.delete();
        obs_ok.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_steady();
        test_underflow();
        test_enable_drop();
        test_overflow();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
